// File: rtl/phy_rx_align_n.sv
// rtl/phy_rx_align_n.sv - serial receive symbol aligner and lane de-striper
//
// Purpose: hunts for the COM symbol in a 1-bit MSB-first serial stream, declares
// lock after LOCK_COUNT aligned COMs and then delivers every non-COM symbol
// round-robin across CHANNELS logical lanes, tagged with its lane index.
// Loss of lock after MAX_GAP consecutive non-COM symbols.
// Ports:
//   clk         serial bit clock, one bit per cycle
//   reset       asynchronous, active-high
//   data_in     serial bit, MSB of each symbol first
//   data_out    last delivered data symbol (held between strobes)
//   valid_out   one-cycle strobe qualifying data_out/channel_out
//   channel_out lane index of the delivered symbol
//   locked      high while aligned and de-striping
module phy_rx_align_n #(
    parameter int unsigned  W          = 8,
    parameter logic [W-1:0] COM        = 8'hBC,
    parameter int unsigned  CHANNELS   = 4,
    parameter int unsigned  LOCK_COUNT = 4,
    parameter int unsigned  MAX_GAP    = 16,
    localparam int unsigned CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          data_in,
    output logic [W-1:0]  data_out,
    output logic          valid_out,
    output logic [CW-1:0] channel_out,
    output logic          locked
);

    localparam int unsigned BW  = $clog2(W);
    localparam int unsigned CCW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned GW  = $clog2(MAX_GAP);

    localparam logic [BW-1:0]  BIT_LAST   = BW'(W - 1);
    localparam logic [CW-1:0]  CHAN_LAST  = CW'(CHANNELS - 1);
    localparam logic [GW-1:0]  GAP_LAST   = GW'(MAX_GAP - 1);
    localparam logic [CCW-1:0] COM_TARGET = CCW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        SEARCH,
        ALIGNING,
        LOCKED
    } state_t;

    state_t         state, state_n;
    logic [W-1:0]   sr;
    logic [BW-1:0]  bit_cnt, bit_cnt_n;
    logic [CCW-1:0] com_cnt, com_cnt_n;
    logic [GW-1:0]  gap_cnt, gap_cnt_n;
    logic [CW-1:0]  chan_cnt, chan_cnt_n;
    logic           strobe;
    logic           boundary;
    logic           is_com;

    assign boundary = (bit_cnt == BIT_LAST);
    assign is_com   = (sr == COM);
    assign locked   = (state == LOCKED);

    always_comb begin
        state_n    = state;
        bit_cnt_n  = boundary ? '0 : bit_cnt + BW'(1);
        com_cnt_n  = com_cnt;
        gap_cnt_n  = gap_cnt;
        chan_cnt_n = chan_cnt;
        strobe     = 1'b0;

        case (state)
            SEARCH: begin
                // A COM seen now starts the symbol grid: next boundary is W cycles away.
                if (is_com) begin
                    bit_cnt_n = '0;
                    com_cnt_n = CCW'(1);
                    if (LOCK_COUNT == 1) begin
                        state_n    = LOCKED;
                        chan_cnt_n = '0;
                        gap_cnt_n  = '0;
                    end else begin
                        state_n = ALIGNING;
                    end
                end
            end

            ALIGNING: begin
                if (boundary) begin
                    if (is_com) begin
                        com_cnt_n = com_cnt + CCW'(1);
                        if (com_cnt + CCW'(1) == COM_TARGET) begin
                            state_n    = LOCKED;
                            chan_cnt_n = '0;
                            gap_cnt_n  = '0;
                        end
                    end else begin
                        state_n   = SEARCH;
                        com_cnt_n = '0;
                    end
                end
            end

            LOCKED: begin
                if (boundary) begin
                    // Every slot, idle or data, consumes one lane.
                    chan_cnt_n = (chan_cnt == CHAN_LAST) ? '0 : chan_cnt + CW'(1);
                    if (is_com) begin
                        gap_cnt_n = '0;
                    end else if (gap_cnt != GAP_LAST) begin
                        strobe    = 1'b1;
                        gap_cnt_n = gap_cnt + GW'(1);
                    end else begin
                        // Too long without an idle: drop this symbol and re-hunt.
                        state_n    = SEARCH;
                        bit_cnt_n  = '0;
                        com_cnt_n  = '0;
                        gap_cnt_n  = '0;
                        chan_cnt_n = '0;
                    end
                end
            end

            default: begin
                state_n = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= SEARCH;
            sr          <= '0;
            bit_cnt     <= '0;
            com_cnt     <= '0;
            gap_cnt     <= '0;
            chan_cnt    <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            channel_out <= '0;
        end else begin
            state     <= state_n;
            sr        <= {sr[W-2:0], data_in};
            bit_cnt   <= bit_cnt_n;
            com_cnt   <= com_cnt_n;
            gap_cnt   <= gap_cnt_n;
            chan_cnt  <= chan_cnt_n;
            valid_out <= strobe;
            if (strobe) begin
                data_out    <= sr;
                channel_out <= chan_cnt;
            end
        end
    end

endmodule

// File: tb/tb_phy_rx_align_n.sv
// tb/tb_phy_rx_align_n.sv - directed self-checking bench for phy_rx_align_n
module tb_phy_rx_align_n;

    logic       clk = 1'b0;
    logic       reset;
    logic       din8;
    logic       din10;
    logic [7:0] dout8;
    logic       v8;
    logic [1:0] ch8;
    logic       lk8;
    logic [9:0] dout10;
    logic       v10;
    logic [0:0] ch10;
    logic       lk10;

    always #5 clk = ~clk;

    phy_rx_align_n dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (din8),
        .data_out    (dout8),
        .valid_out   (v8),
        .channel_out (ch8),
        .locked      (lk8)
    );

    phy_rx_align_n #(
        .W          (10),
        .COM        (10'h17C),
        .CHANNELS   (2),
        .LOCK_COUNT (2),
        .MAX_GAP    (16)
    ) dut_g (
        .clk         (clk),
        .reset       (reset),
        .data_in     (din10),
        .data_out    (dout10),
        .valid_out   (v10),
        .channel_out (ch10),
        .locked      (lk10)
    );

    int errors = 0;
    int checks = 0;

    bit bits[$];
    bit lk_log[$];
    int ev_idx[$];
    int ev_dat[$];
    int ev_ch[$];
    int ex_idx[$];
    int ex_dat[$];
    int ex_ch[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_sym(input int s, input int w);
        for (int i = w - 1; i >= 0; i--) bits.push_back(s[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        din8  = 1'b0;
        din10 = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Sample index i is taken 1 time unit after the posedge that clocks bit i.
    task automatic run(input bit sel, input int pad);
        for (int i = 0; i < pad; i++) bits.push_back(1'b0);
        lk_log.delete();
        ev_idx.delete();
        ev_dat.delete();
        ev_ch.delete();
        for (int i = 0; i < bits.size(); i++) begin
            if (sel) begin
                din10 = bits[i];
                din8  = 1'b0;
            end else begin
                din8  = bits[i];
                din10 = 1'b0;
            end
            @(posedge clk);
            #1;
            if (sel) begin
                lk_log.push_back(lk10);
                if (v10) begin
                    ev_idx.push_back(i);
                    ev_dat.push_back(int'(dout10));
                    ev_ch.push_back(int'(ch10));
                end
            end else begin
                lk_log.push_back(lk8);
                if (v8) begin
                    ev_idx.push_back(i);
                    ev_dat.push_back(int'(dout8));
                    ev_ch.push_back(int'(ch8));
                end
            end
        end
        bits.delete();
    endtask

    task automatic expect_ev(input int idx, input int dat, input int ch);
        ex_idx.push_back(idx);
        ex_dat.push_back(dat);
        ex_ch.push_back(ch);
    endtask

    task automatic compare_events(input string tag);
        int n;
        check($sformatf("%s_count", tag), ev_idx.size(), ex_idx.size());
        n = (ev_idx.size() < ex_idx.size()) ? ev_idx.size() : ex_idx.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_idx%0d", tag, i), ev_idx[i], ex_idx[i]);
            check($sformatf("%s_dat%0d", tag, i), ev_dat[i], ex_dat[i]);
            check($sformatf("%s_ch%0d", tag, i), ev_ch[i], ex_ch[i]);
        end
        ex_idx.delete();
        ex_dat.delete();
        ex_ch.delete();
    endtask

    initial begin
        int syms[$];
        int cnt;

        // Reset state
        reset = 1'b1;
        din8  = 1'b0;
        din10 = 1'b0;
        @(posedge clk);
        #1;
        check("rst_data", dout8, 0);
        check("rst_valid", v8, 0);
        check("rst_chan", ch8, 0);
        check("rst_locked", lk8, 0);
        check("rst_locked_g", lk10, 0);
        reset = 1'b0;

        // Lock and de-stripe: 3 junk bits, 4xBC, 11 BC 33 44
        do_reset();
        push_sym(0, 3);
        for (int i = 0; i < 4; i++) push_sym(8'hBC, 8);
        push_sym(8'h11, 8);
        push_sym(8'hBC, 8);
        push_sym(8'h33, 8);
        push_sym(8'h44, 8);
        run(1'b0, 2);
        check("lock_pre", lk_log[34], 0);
        check("lock_rise", lk_log[35], 1);
        expect_ev(43, 8'h11, 0);
        expect_ev(59, 8'h33, 2);
        expect_ev(67, 8'h44, 3);
        compare_events("destripe");

        // Failed lock: 3xBC then 55, then 4xBC
        do_reset();
        for (int i = 0; i < 3; i++) push_sym(8'hBC, 8);
        push_sym(8'h55, 8);
        for (int i = 0; i < 4; i++) push_sym(8'hBC, 8);
        run(1'b0, 2);
        cnt = 0;
        for (int i = 0; i < 64; i++) if (lk_log[i]) cnt++;
        check("fail_nolock", cnt, 0);
        check("fail_relock", lk_log[64], 1);
        compare_events("fail");

        // Lane wrap and gap reset by an idle slot
        do_reset();
        for (int i = 0; i < 4; i++) push_sym(8'hBC, 8);
        syms = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        for (int i = 0; i < 10; i++) syms.push_back(8'h20 + i);
        syms.push_back(8'hBC);
        for (int i = 0; i < 15; i++) syms.push_back(8'h30 + i);
        foreach (syms[m]) begin
            push_sym(syms[m], 8);
            if (syms[m] != 8'hBC) expect_ev(8 * (4 + m) + 8, syms[m], m % 4);
        end
        run(1'b0, 2);
        compare_events("wrap");
        check("wrap_still_locked", lk_log[lk_log.size() - 1], 1);

        // Loss of lock: 16 non-COM symbols 01..10
        do_reset();
        for (int i = 0; i < 4; i++) push_sym(8'hBC, 8);
        for (int m = 0; m < 16; m++) begin
            push_sym(m + 1, 8);
            if (m < 15) expect_ev(40 + 8 * m, m + 1, m % 4);
        end
        run(1'b0, 2);
        compare_events("loss");
        check("loss_lk_before", lk_log[159], 1);
        check("loss_lk_after", lk_log[160], 0);
        check("hold_data", dout8, 8'h0F);
        check("hold_chan", ch8, 2);

        // Reset mid-stream while ALIGNING
        push_sym(8'hBC, 8);
        push_sym(8'hBC, 8);
        run(1'b0, 0);
        check("mid_aligning_unlocked", lk8, 0);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_data", dout8, 0);
        check("mid_rst_chan", ch8, 0);
        check("mid_rst_valid", v8, 0);
        check("mid_rst_locked", lk8, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) push_sym(8'hBC, 8);
        push_sym(8'h5A, 8);
        run(1'b0, 2);
        check("mid_relock_pre", lk_log[31], 0);
        check("mid_relock", lk_log[32], 1);
        expect_ev(40, 8'h5A, 0);
        compare_events("mid");

        // Generic build: W=10, COM=17C, 2 lanes, lock after 2 COMs
        do_reset();
        push_sym(10'h17C, 10);
        push_sym(10'h17C, 10);
        syms = '{10'h001, 10'h3FF, 10'h155, 10'h2AA, 10'h0F0};
        foreach (syms[m]) begin
            push_sym(syms[m], 10);
            expect_ev(30 + 10 * m, syms[m], m % 2);
        end
        run(1'b1, 2);
        check("gen_lock_pre", lk_log[19], 0);
        check("gen_lock", lk_log[20], 1);
        compare_events("gen");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
